firebird7_in_gate1_tessent_data_mux_ctrl: RTL

//  Sequences the select of one W-bit IJTAG data-override mux that sits on the functional path.
//  On an IJTAG override request it:
//   - stalls the functional side and waits for it to go idle (bounded by a timeout);
//   - drives the mux select and the override data;
//   - releases the mux after a guard window.

---
 rtl/firebird7_in_gate1_tessent_data_mux_ctrl_pkg.sv | 10 +
 rtl/firebird7_in_gate1_tessent_data_mux_ctrl_if.sv | 26 ++
 rtl/firebird7_in_gate1_tessent_data_mux_ctrl_fsm.sv | 63 ++++++
 rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv | 39 +++
 4 files changed

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_pkg.sv
// firebird7_in_gate1_tessent_data_mux_ctrl_pkg: shared state type and counter sizing
package firebird7_in_gate1_tessent_data_mux_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, OVERRIDE, RELEASE} state_t;
  function automatic int cnt_w(int a, int b, int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_if.sv
// firebird7_in_gate1_tessent_data_mux_ctrl_if: IJTAG, functional and mux-side signal bundle
interface firebird7_in_gate1_tessent_data_mux_ctrl_if #(parameter int W = 19) ();
  logic         ijtag_override_req;
  logic         ijtag_ue;
  logic         ijtag_ce;
  logic [W-1:0] ijtag_data;
  logic         ijtag_clear_status;
  logic         func_idle;
  logic [W-1:0] mux_data_out;
  logic         func_hold;
  logic         mux_select;
  logic [W-1:0] mux_ijtag_data;
  logic [W-1:0] capture_data;
  logic         status_active;
  logic         status_timeout;
  modport slave (
    input  ijtag_override_req, ijtag_ue, ijtag_ce, ijtag_data, ijtag_clear_status,
           func_idle, mux_data_out,
    output func_hold, mux_select, mux_ijtag_data, capture_data, status_active, status_timeout
  );
  modport master (
    output ijtag_override_req, ijtag_ue, ijtag_ce, ijtag_data, ijtag_clear_status,
           func_idle, mux_data_out,
    input  func_hold, mux_select, mux_ijtag_data, capture_data, status_active, status_timeout
  );
endinterface

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_fsm.sv
// firebird7_in_gate1_tessent_data_mux_ctrl_fsm: override sequencer with shared saturating counter
module firebird7_in_gate1_tessent_data_mux_ctrl_fsm
  import firebird7_in_gate1_tessent_data_mux_ctrl_pkg::*;
#(
  parameter int TO_CYC   = 64,
  parameter int MIN_HOLD = 4,
  parameter int GUARD    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic func_idle_i,
  input  logic clear_i,
  output logic func_hold_o,
  output logic mux_select_o,
  output logic status_active_o,
  output logic status_timeout_o
);
  localparam int CW = cnt_w(TO_CYC, MIN_HOLD, GUARD);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo;
  logic          hold_q, sel_q, timeout_q;
  always_comb begin
    state_d = state_q;
    tmo     = 1'b0;
    case (state_q)
      IDLE:     if (req_i) state_d = DRAIN;
      DRAIN: begin
        if (!req_i) state_d = RELEASE;
        else if (func_idle_i) state_d = OVERRIDE;
        else if (cnt_q == CW'(TO_CYC - 1)) begin
          state_d = OVERRIDE;
          tmo     = 1'b1;
        end
      end
      OVERRIDE: if (!req_i && cnt_q >= CW'(MIN_HOLD)) state_d = RELEASE;
      RELEASE:  if (cnt_q == CW'(GUARD - 1)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
  end
  // Outputs are flopped from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_q    <= 1'b0;
      sel_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= state_d != IDLE;
      sel_q     <= state_d == OVERRIDE;
      timeout_q <= tmo | (timeout_q & ~clear_i);
    end
  end
  assign func_hold_o      = hold_q;
  assign mux_select_o     = sel_q;
  assign status_active_o  = sel_q;
  assign status_timeout_o = timeout_q;
endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// firebird7_in_gate1_tessent_data_mux_ctrl: sequences an IJTAG data-override mux and shadows its output
module firebird7_in_gate1_tessent_data_mux_ctrl
  import firebird7_in_gate1_tessent_data_mux_ctrl_pkg::*;
#(
  parameter int W        = 19,
  parameter int TO_CYC   = 64,
  parameter int MIN_HOLD = 4,
  parameter int GUARD    = 2
) (
  input logic ijtag_tck,
  input logic ijtag_reset,
  firebird7_in_gate1_tessent_data_mux_ctrl_if.slave bus
);
  logic [W-1:0] data_q, cap_q;
  firebird7_in_gate1_tessent_data_mux_ctrl_fsm #(
    .TO_CYC(TO_CYC), .MIN_HOLD(MIN_HOLD), .GUARD(GUARD)
  ) u_fsm (
    .clk(ijtag_tck),
    .rst(ijtag_reset),
    .req_i(bus.ijtag_override_req),
    .func_idle_i(bus.func_idle),
    .clear_i(bus.ijtag_clear_status),
    .func_hold_o(bus.func_hold),
    .mux_select_o(bus.mux_select),
    .status_active_o(bus.status_active),
    .status_timeout_o(bus.status_timeout)
  );
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      data_q <= '0;
      cap_q  <= '0;
    end else begin
      if (bus.ijtag_ue) data_q <= bus.ijtag_data;
      if (bus.ijtag_ce) cap_q <= bus.mux_data_out;
    end
  end
  assign bus.mux_ijtag_data = data_q;
  assign bus.capture_data   = cap_q;
endmodule
